// File: rtl/sprite_board_updater_pkg.sv
// sprite_board_updater_pkg: shared board geometry defaults, tile codes and updater FSM states.
// No ports. Imported by the board updater, its arbiter and its bus interface users.
package sprite_board_updater_pkg;
    localparam int DEF_NUM_SPRITES = 5;
    localparam int DEF_BOARD_W     = 32;
    localparam int DEF_BOARD_H     = 24;
    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_TYPE_W      = 4;
    // Sprite 0 (PacMan) starts at block 495; ghosts start in the pen row above.
    localparam logic [DEF_NUM_SPRITES*DEF_ADDR_W-1:0] DEF_INIT_LOC =
        {10'd370, 10'd369, 10'd368, 10'd367, 10'd495};
    typedef enum logic [DEF_TYPE_W-1:0] {
        EMPTY  = 4'd0,
        WALL   = 4'd1,
        PELLET = 4'd2,
        PAC    = 4'd3,
        BLINKY = 4'd4,
        PINKY  = 4'd5,
        INKY   = 4'd6,
        CLYDE  = 4'd7
    } tile_t;
    typedef enum logic [2:0] {IDLE, SELECT, READ, WAIT, ERASE, DRAW, COMMIT} upd_state_t;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sprite_board_updater_if.sv
// sprite_board_updater_if: board RAM update-side port (read address/data, write enable/address/data).
// master = updater (drives rd_addr, wren, write_addr, write_data); slave = board RAM (drives rd_data).
interface sprite_board_updater_if #(
    parameter int ADDR_W = 10,
    parameter int TYPE_W = 4
);
    logic [ADDR_W-1:0] rd_addr;
    logic [TYPE_W-1:0] rd_data;
    logic              wren;
    logic [ADDR_W-1:0] write_addr;
    logic [TYPE_W-1:0] write_data;
    modport master (output rd_addr, wren, write_addr, write_data, input rd_data);
    modport slave  (input rd_addr, wren, write_addr, write_data, output rd_data);
endinterface

// File: rtl/sprite_board_updater_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the lowest pending index at/after last+1.
// Ports: pend (request mask), last (previously served index) -> grant (chosen index), valid (any request).
module rr_arbiter
    import sprite_board_updater_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  pend,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          valid
);
    // Scan from farthest to nearest so the nearest request after last wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (pend[(int'(last) + k) % N]) begin
                grant = IW'((int'(last) + k) % N);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sprite_board_updater.sv
// sprite_board_updater: per game tick, erases each moved sprite's old block, restores what lay beneath it and draws it at its new block.
// Ports: clk, reset_n (async, active-low), tick (game-step strobe), restart (sync game restart),
//   next_loc/sprite_tile (per-sprite request and tile), bus (board RAM update port, master side),
//   cur_loc (committed locations), move_ack (commit pulse), bad_loc (sticky off-board request),
//   collision (PacMan shares a block with a ghost), busy (FSM not idle).
module sprite_board_updater
    import sprite_board_updater_pkg::*;
#(
    parameter int NUM_SPRITES = DEF_NUM_SPRITES,
    parameter int BOARD_W     = DEF_BOARD_W,
    parameter int BOARD_H     = DEF_BOARD_H,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int TYPE_W      = DEF_TYPE_W,
    parameter logic [NUM_SPRITES-1:0] EATS_MASK = NUM_SPRITES'(1),
    parameter logic [NUM_SPRITES*ADDR_W-1:0] INIT_LOC = DEF_INIT_LOC
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          tick,
    input  logic                          restart,
    input  logic [NUM_SPRITES*ADDR_W-1:0] next_loc,
    input  logic [NUM_SPRITES*TYPE_W-1:0] sprite_tile,
    sprite_board_updater_if.master        bus,
    output logic [NUM_SPRITES*ADDR_W-1:0] cur_loc,
    output logic [NUM_SPRITES-1:0]        move_ack,
    output logic [NUM_SPRITES-1:0]        bad_loc,
    output logic                          collision,
    output logic                          busy
);
    localparam int IW = idx_w(NUM_SPRITES);
    // One extra bit so a board filling the whole address space still compares correctly.
    localparam logic [ADDR_W:0] CELLS = (ADDR_W+1)'(BOARD_W * BOARD_H);

    upd_state_t              state, state_nx;
    logic [NUM_SPRITES-1:0]  pend, pend_tick, pend_rest;
    logic [IW-1:0]           last, idx, grant;
    logic                    gvalid, sel_bad, coll_nx;
    logic [ADDR_W-1:0]       held;
    logic [TYPE_W-1:0]       cap, cap_nx, erase_data;
    logic [ADDR_W-1:0]       cur_q [NUM_SPRITES];
    logic [ADDR_W-1:0]       nl    [NUM_SPRITES];
    logic [TYPE_W-1:0]       st    [NUM_SPRITES];
    logic [TYPE_W-1:0]       under [NUM_SPRITES];

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_sprite
        assign nl[g]        = next_loc[g*ADDR_W +: ADDR_W];
        assign st[g]        = sprite_tile[g*TYPE_W +: TYPE_W];
        assign cur_loc[g*ADDR_W +: ADDR_W] = cur_q[g];
        assign pend_tick[g] = nl[g] != cur_q[g];
    end

    rr_arbiter #(.N(NUM_SPRITES)) u_arb (
        .pend  (pend),
        .last  (last),
        .grant (grant),
        .valid (gvalid)
    );

    assign sel_bad   = {1'b0, nl[grant]} >= CELLS;
    // SELECT retires the granted sprite (bad request); COMMIT retires the one in flight.
    assign pend_rest = pend & ~(NUM_SPRITES'(1) << (state == SELECT ? grant : idx));

    // Stacked sprites: the board shows a co-located sprite, not the raw RAM tile.
    always_comb begin
        erase_data = EATS_MASK[idx] ? TYPE_W'(EMPTY) : under[idx];
        cap_nx     = bus.rd_data;
        coll_nx    = 1'b0;
        for (int j = 0; j < NUM_SPRITES; j++) begin
            if (IW'(j) != idx && cur_q[j] == cur_q[idx]) erase_data = st[j];
            if (IW'(j) != idx && cur_q[j] == held) cap_nx = under[j];
            if (j > 0 && cur_q[j] == cur_q[0]) coll_nx = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = tick && |pend_tick ? SELECT : IDLE;
            SELECT:  state_nx = !gvalid ? IDLE : !sel_bad ? READ : |pend_rest ? SELECT : IDLE;
            READ:    state_nx = WAIT;
            WAIT:    state_nx = ERASE;
            ERASE:   state_nx = DRAW;
            DRAW:    state_nx = COMMIT;
            COMMIT:  state_nx = |pend_rest ? SELECT : IDLE;
            default: state_nx = IDLE;
        endcase
        if (restart) state_nx = IDLE;
    end

    assign bus.wren       = state == ERASE || state == DRAW;
    assign bus.write_addr = state == ERASE ? cur_q[idx] : state == DRAW ? held : '0;
    assign bus.write_data = state == ERASE ? erase_data : state == DRAW ? st[idx] : '0;
    assign bus.rd_addr    = state == READ ? held : '0;
    assign busy           = state != IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend      <= '0;
            last      <= IW'(NUM_SPRITES - 1);
            idx       <= '0;
            held      <= '0;
            cap       <= '0;
            move_ack  <= '0;
            bad_loc   <= '0;
            collision <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                cur_q[i] <= INIT_LOC[i*ADDR_W +: ADDR_W];
                under[i] <= '0;
            end
        end else begin
            move_ack  <= '0;
            collision <= coll_nx;
            if (restart) begin
                pend <= '0;
                last <= IW'(NUM_SPRITES - 1);
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    cur_q[i] <= INIT_LOC[i*ADDR_W +: ADDR_W];
                    under[i] <= '0;
                end
            end else begin
                unique case (state)
                    IDLE: if (tick) pend <= pend_tick;
                    SELECT: if (gvalid) begin
                        idx  <= grant;
                        held <= nl[grant];
                        last <= grant;
                        if (sel_bad) begin
                            bad_loc[grant] <= 1'b1;
                            pend           <= pend_rest;
                        end
                    end
                    WAIT: cap <= cap_nx;
                    DRAW: under[idx] <= cap;
                    COMMIT: begin
                        cur_q[idx]    <= held;
                        move_ack[idx] <= 1'b1;
                        pend          <= pend_rest;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sprite_board_updater.sv
// tb_sprite_board_updater: randomized and directed checks of the board updater against a per-move reference model.
module tb_sprite_board_updater;
    localparam int N = 5;
    localparam int CELLS = 768;
    localparam int INIT[N] = '{495, 367, 368, 369, 370};
    localparam int TILE[N] = '{3, 4, 5, 6, 7};

    logic clk = 1'b0, reset_n = 1'b0, tick = 1'b0, restart = 1'b0;
    logic [N*10-1:0] next_loc, cur_loc;
    logic [N*4-1:0]  sprite_tile;
    logic [N-1:0]    move_ack, bad_loc;
    logic            collision, busy;
    logic [3:0]      ram [1024];
    logic [3:0]      rd_q = '0;

    int checks = 0, errors = 0;
    int nxt[N];
    int m_loc[N], m_under[N], m_last, mv_cnt, bad_cnt, first_ack;
    logic [N-1:0] m_bad;
    logic [3:0]   m_ram [1024];
    int ew_a[$], ew_d[$], eack[$], dw_a[$], dw_d[$], dack[$];

    sprite_board_updater_if #(.ADDR_W(10), .TYPE_W(4)) bus ();

    sprite_board_updater dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (tick),
        .restart     (restart),
        .next_loc    (next_loc),
        .sprite_tile (sprite_tile),
        .bus         (bus),
        .cur_loc     (cur_loc),
        .move_ack    (move_ack),
        .bad_loc     (bad_loc),
        .collision   (collision),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    assign bus.rd_data = rd_q;

    always @(posedge clk) begin
        rd_q <= ram[bus.rd_addr];
        if (bus.wren) ram[bus.write_addr] <= bus.write_data;
    end

    always @(negedge clk) begin
        if (bus.wren) begin
            dw_a.push_back(int'(bus.write_addr));
            dw_d.push_back(int'(bus.write_data));
        end
        for (int i = 0; i < N; i++) if (move_ack[i]) dack.push_back(i);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*10-1:0] pack_loc(input int l[N]);
        logic [N*10-1:0] v;
        for (int i = 0; i < N; i++) v[i*10 +: 10] = 10'(l[i]);
        return v;
    endfunction

    // Sprite-level model: service pending sprites round-robin, each as erase + draw.
    task automatic model_tick();
        bit pend[N];
        int i, ed, cap;
        mv_cnt = 0;
        bad_cnt = 0;
        ew_a.delete(); ew_d.delete(); eack.delete();
        for (int s = 0; s < N; s++) pend[s] = nxt[s] != m_loc[s];
        while (1) begin
            i = -1;
            for (int k = 1; k <= N; k++) if (i < 0 && pend[(m_last + k) % N]) i = (m_last + k) % N;
            if (i < 0) break;
            m_last = i;
            pend[i] = 0;
            if (nxt[i] >= CELLS) begin
                m_bad[i] = 1'b1;
                bad_cnt++;
                continue;
            end
            ed = (i == 0) ? 0 : m_under[i];
            cap = int'(m_ram[nxt[i]]);
            for (int j = 0; j < N; j++) if (j != i) begin
                if (m_loc[j] == m_loc[i]) ed = TILE[j];
                if (m_loc[j] == nxt[i]) cap = m_under[j];
            end
            ew_a.push_back(m_loc[i]); ew_d.push_back(ed);
            ew_a.push_back(nxt[i]);   ew_d.push_back(TILE[i]);
            m_ram[m_loc[i]] = 4'(ed);
            m_ram[nxt[i]]   = 4'(TILE[i]);
            m_under[i] = cap;
            m_loc[i] = nxt[i];
            eack.push_back(i);
            mv_cnt++;
        end
    endtask

    function automatic bit m_coll();
        bit c = 0;
        for (int j = 1; j < N; j++) if (m_loc[j] == m_loc[0]) c = 1;
        return c;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            m_loc[i] = INIT[i];
            m_under[i] = 0;
            nxt[i] = INIT[i];
        end
        m_last = N - 1;
        m_bad = '0;
    endtask

    task automatic apply_next();
        for (int i = 0; i < N; i++) next_loc[i*10 +: 10] = 10'(nxt[i]);
    endtask

    task automatic run_tick(input bit spurious);
        int cyc = 0;
        apply_next();
        model_tick();
        dw_a.delete(); dw_d.delete(); dack.delete();
        first_ack = 0;
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (move_ack != '0 && first_ack == 0) first_ack = cyc;
            if (!busy || cyc > 60) break;
            tick = spurious && cyc == 3;
        end
        tick = 1'b0;
        chk("cycles", cyc, 1 + 6 * mv_cnt + bad_cnt);
        @(negedge clk);
        chk("n_writes", dw_a.size(), ew_a.size());
        for (int k = 0; k < dw_a.size() && k < ew_a.size(); k++) begin
            chk("wr_addr", dw_a[k], ew_a[k]);
            chk("wr_data", dw_d[k], ew_d[k]);
        end
        chk("n_acks", dack.size(), eack.size());
        for (int k = 0; k < dack.size() && k < eack.size(); k++) chk("ack_order", dack[k], eack[k]);
        chk("cur_loc", cur_loc, pack_loc(m_loc));
        chk("bad_loc", bad_loc, m_bad);
        chk("collision", collision, m_coll());
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < N; i++) sprite_tile[i*4 +: 4] = 4'(TILE[i]);
        for (int a = 0; a < 1024; a++) begin
            ram[a] = 4'($urandom_range(0, 2));
            m_ram[a] = ram[a];
        end
        for (int i = 0; i < N; i++) nxt[i] = INIT[i];
        apply_next();
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_wren", bus.wren, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_cur_loc", cur_loc, pack_loc(INIT));
        chk("rst_bad_loc", bad_loc, 0);
        chk("rst_collision", collision, 0);
        chk("rst_move_ack", move_ack, 0);

        // No movement requested: nothing happens.
        run_tick(0);
        chk("idle_no_writes", dw_a.size(), 0);

        // All five move on one tick: served 0..4.
        for (int i = 0; i < N; i++) nxt[i] = INIT[i] + 32;
        run_tick(0);
        for (int k = 0; k < N; k++) if (k < dack.size()) chk("all5_order", dack[k], k);
        chk("all5_writes", dw_a.size(), 10);

        // PacMan eats a pellet.
        do_reset();
        ram[496] = 4'd2; m_ram[496] = 4'd2;
        nxt[0] = 496;
        run_tick(0);
        chk("pac_ack_lat", first_ack - 1, 6);
        if (dw_a.size() >= 2) begin
            chk("pac_erase_a", dw_a[0], 495);
            chk("pac_erase_d", dw_d[0], 0);
            chk("pac_draw_a", dw_a[1], 496);
            chk("pac_draw_d", dw_d[1], 3);
        end

        // Ghost crosses a pellet and puts it back.
        ram[400] = 4'd2; m_ram[400] = 4'd2;
        nxt[1] = 400;
        run_tick(1);
        nxt[1] = 401;
        run_tick(0);
        if (dw_a.size() >= 1) begin
            chk("ghost_restore_a", dw_a[0], 400);
            chk("ghost_restore_d", dw_d[0], 2);
        end

        // Off-board request.
        do_reset();
        for (int i = 0; i < N; i++) nxt[i] = INIT[i] + 64;
        nxt[2] = 800;
        run_tick(0);
        chk("bad_loc2", bad_loc[2], 1);

        // Restart during DRAW.
        do_reset();
        nxt[2] = 600;
        apply_next();
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(bus.wren && bus.write_addr == 10'd600) && cyc < 20);
        chk("draw_seen", cyc < 20, 1);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("rs_wren", bus.wren, 0);
        chk("rs_busy", busy, 0);
        chk("rs_cur_loc", cur_loc, pack_loc(INIT));
        for (int a = 0; a < 1024; a++) m_ram[a] = ram[a];

        // Ghost lands on PacMan.
        do_reset();
        nxt[1] = 495;
        run_tick(0);
        chk("collide", collision, 1);

        // Randomized ticks.
        do_reset();
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                int r = $urandom_range(0, 9);
                if (m_loc[i] >= CELLS) nxt[i] = m_loc[i];
                if (r >= 5 && r <= 7) nxt[i] = (m_loc[i] + (r == 5 ? 1 : r == 6 ? CELLS - 1 : 32)) % CELLS;
                else if (r == 8) nxt[i] = m_loc[$urandom_range(0, N - 1)];
                else if (r == 9) nxt[i] = $urandom_range(0, 1023);
                else nxt[i] = m_loc[i];
            end
            run_tick($urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
